// File: rtl/uart_cmd_pkg.sv
// Shared encodings for the UART command decoder: op codes, FSM states and
// the ASCII characters the line parser recognises.
package uart_cmd_pkg;

  localparam logic [1:0] OP_INC = 2'd0;
  localparam logic [1:0] OP_DEC = 2'd1;
  localparam logic [1:0] OP_SET = 2'd2;
  localparam logic [1:0] OP_CLR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OP_WAIT,
    ST_DIGITS,
    ST_DISCARD
  } state_e;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_D  = 8'h44;
  localparam logic [7:0] ASCII_I  = 8'h49;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_S  = 8'h53;

  // Folds lower-case letters onto upper case so op letters compare once.
  function automatic logic [7:0] to_upper(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    return b;
  endfunction

endpackage

// File: rtl/uart_cmd_decoder.sv
// Line-oriented command parser: turns "I", "D", "R" and "S<decimal>" lines
// from a UART byte stream into one-cycle command or error strobes.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int ARG_WIDTH  = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 cmd_valid,
  output logic [1:0]           cmd_op,
  output logic [ARG_WIDTH-1:0] cmd_arg,
  output logic                 cmd_err
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int PW = ARG_WIDTH + 4;

  state_e               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [ARG_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic                 cmd_err_q, cmd_err_d;
  logic [1:0]           cmd_op_q, cmd_op_d;
  logic [ARG_WIDTH-1:0] cmd_arg_q, cmd_arg_d;

  logic [7:0]    upper;
  logic          is_term;
  logic          is_digit;
  logic [PW-1:0] acc_wide;
  logic          digit_ovf;

  assign upper    = to_upper(rx_data);
  assign is_term  = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
  assign is_digit = (rx_data >= ASCII_0) && (rx_data <= ASCII_9);

  // acc*10 + digit in a 4-bit-wider word so overflow past the argument
  // range is visible before the value is committed.
  assign acc_wide  = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1)
                   + {{(PW-4){1'b0}}, rx_data[3:0]};
  assign digit_ovf = (count_q == CW'(MAX_DIGITS))
                   || (acc_wide > {4'b0, {ARG_WIDTH{1'b1}}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_INC;
      acc_q       <= '0;
      count_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      cmd_op_q    <= 2'd0;
      cmd_arg_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_err_q   <= cmd_err_d;
      cmd_op_q    <= cmd_op_d;
      cmd_arg_q   <= cmd_arg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    count_d = count_q;
    if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (!is_term) begin
            case (upper)
              ASCII_I: begin op_d = OP_INC; state_d = ST_OP_WAIT; end
              ASCII_D: begin op_d = OP_DEC; state_d = ST_OP_WAIT; end
              ASCII_R: begin op_d = OP_CLR; state_d = ST_OP_WAIT; end
              ASCII_S: begin
                acc_d   = '0;
                count_d = '0;
                state_d = ST_DIGITS;
              end
              default: state_d = ST_DISCARD;
            endcase
          end
        end
        ST_OP_WAIT: state_d = is_term ? ST_IDLE : ST_DISCARD;
        ST_DIGITS: begin
          if (is_term) begin
            state_d = ST_IDLE;
          end else if (is_digit && !digit_ovf) begin
            acc_d   = acc_wide[ARG_WIDTH-1:0];
            count_d = count_q + CW'(1);
          end else begin
            state_d = ST_DISCARD;
          end
        end
        ST_DISCARD: if (is_term) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_valid_d = 1'b0;
    cmd_err_d   = 1'b0;
    cmd_op_d    = cmd_op_q;
    cmd_arg_d   = cmd_arg_q;
    if (rx_valid && is_term) begin
      case (state_q)
        ST_OP_WAIT: begin
          cmd_valid_d = 1'b1;
          cmd_op_d    = op_q;
          cmd_arg_d   = '0;
        end
        ST_DIGITS: begin
          if (count_q != '0) begin
            cmd_valid_d = 1'b1;
            cmd_op_d    = OP_SET;
            cmd_arg_d   = acc_q;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        ST_DISCARD: cmd_err_d = 1'b1;
        default: ;
      endcase
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_err   = cmd_err_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_arg   = cmd_arg_q;

endmodule
